// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a single-outstanding
// req/addr_ok/data_ok SRAM port and buffers one instruction for the IF->ID handoff.
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR  = 32'hbfc0_0000,
    parameter logic [31:0] EXCEPT_ADDR = 32'hbfc0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_CANCEL = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        flush_s;
    logic [31:0] flush_tgt_s;
    logic [31:0] next_pc_s;
    logic        consume_s;

    assign flush_s     = trap | eret;
    assign flush_tgt_s = trap ? EXCEPT_ADDR : epc;
    assign next_pc_s   = br_taken     ? br_target :
                         pend_valid_q ? pend_target_q :
                                        fetch_pc_q + 32'd4;
    // A valid return is the only point where a redirect is folded into fetch_pc.
    assign consume_s   = (state_q == ST_WAIT) & inst_data_ok & ~flush_s;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_REQ;
            fetch_pc_q    <= RESET_ADDR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_inst_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
        end
    end

    // Next-state, fetch PC, pending-branch and instruction-buffer logic.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;

        case (state_q)
            ST_REQ: begin
                if (inst_addr_ok) begin
                    state_d = flush_s ? ST_CANCEL : ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush_s) begin
                    state_d = inst_data_ok ? ST_REQ : ST_CANCEL;
                end else if (inst_data_ok) begin
                    if_inst_d  = inst_rdata;
                    if_pc_d    = fetch_pc_q;
                    if_valid_d = 1'b1;
                    fetch_pc_d = next_pc_s;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush_s) begin
                    state_d = ST_REQ;
                end else if (id_allowin) begin
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_CANCEL: begin
                if (inst_data_ok) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_CANCEL;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (flush_s) begin
            fetch_pc_d   = flush_tgt_s;
            pend_valid_d = 1'b0;
            if_valid_d   = 1'b0;
        end else if (consume_s) begin
            pend_valid_d = 1'b0;
        end else if (br_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = br_target;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Reset state is REQ, so the request is masked while rst is held.
    assign inst_req  = (state_q == ST_REQ) & ~rst;
    assign inst_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model of the fetch stage.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_A = 32'hbfc0_0000;
    localparam logic [31:0] EXC_A = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        rst, trap, eret, br_taken, id_allowin;
    logic [31:0] epc, br_target;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .trap(trap), .eret(eret), .epc(epc),
        .br_taken(br_taken), .br_target(br_target), .id_allowin(id_allowin),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Model: the address the next request must carry, whether a fetch is
    // outstanding (and whether it is stale), the one-entry buffer, pending redirect.
    logic [31:0] m_addr, m_buf_pc, m_pend_t;
    logic        m_out, m_stale, m_buf_v, m_pend_v, m_zero;
    // Memory slave
    logic        s_busy;
    int          s_cnt;
    logic [31:0] s_addr;
    logic [31:0] req_log[$];

    task automatic model_reset();
        m_addr = RST_A; m_out = 1'b0; m_stale = 1'b0; m_buf_v = 1'b0;
        m_buf_pc = 32'd0; m_pend_v = 1'b0; m_pend_t = 32'd0; m_zero = 1'b1;
        s_busy = 1'b0; s_cnt = 0; s_addr = 32'd0;
    endtask

    task automatic step(input logic r, input logic t, input logic e, input logic [31:0] ep,
                        input logic b, input logic [31:0] bt, input logic al,
                        input logic aok, input int lat);
        logic exp_req, dok, fl, fire, hand;
        logic [31:0] tg;
        rst = r; trap = t; eret = e; epc = ep; br_taken = b; br_target = bt;
        id_allowin = al; inst_addr_ok = aok;
        inst_data_ok = s_busy && (s_cnt == 0);
        inst_rdata = s_busy ? mem_word(s_addr) : 32'hdead_beef;
        #1;
        exp_req = !r && !m_out && !m_buf_v;
        check("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
        check("inst_addr", inst_addr, m_addr);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_buf_v});
        if (m_buf_v) begin
            check("if_pc", if_pc, m_buf_pc);
            check("if_inst", if_inst, mem_word(m_buf_pc));
        end else if (m_zero) begin
            check("if_pc_rst", if_pc, 32'd0);
            check("if_inst_rst", if_inst, 32'd0);
        end
        if (!r && inst_req && aok) req_log.push_back(inst_addr);
        dok = inst_data_ok;
        if (r) begin
            model_reset();
        end else begin
            fl   = t | e;
            tg   = t ? EXC_A : ep;
            fire = exp_req && aok;
            hand = m_buf_v && al;
            if (fl) begin
                m_addr = tg; m_pend_v = 1'b0; m_buf_v = 1'b0;
                m_out = (m_out && !dok) || fire;
                m_stale = m_out;
            end else begin
                if (dok && m_out && !m_stale) begin
                    m_buf_v = 1'b1; m_buf_pc = m_addr; m_zero = 1'b0;
                    m_addr = b ? bt : (m_pend_v ? m_pend_t : m_addr + 32'd4);
                    m_pend_v = 1'b0;
                end else if (b) begin
                    m_pend_v = 1'b1; m_pend_t = bt;
                end
                if (hand) m_buf_v = 1'b0;
                if (dok) begin m_out = 1'b0; m_stale = 1'b0; end
                if (fire) begin m_out = 1'b1; m_stale = 1'b0; end
            end
            if (dok) s_busy = 1'b0;
            else if (s_busy) s_cnt--;
            if (inst_req && aok) begin s_busy = 1'b1; s_cnt = lat; s_addr = inst_addr; end
        end
        @(negedge clk);
    endtask

    task automatic nominal(input int lat);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, lat);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 0);
        req_log.delete();
    endtask

    task automatic run_log(input int n, input int lat);
        for (int k = 0; k < 40 && req_log.size() < n; k++) nominal(lat);
        check("reach_log", req_log.size(), n);
    endtask

    task automatic run_buf();
        for (int k = 0; k < 40 && !m_buf_v; k++) nominal(0);
        check("reach_buf", {31'd0, m_buf_v}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; trap = 1'b0; eret = 1'b0; epc = 32'd0; br_taken = 1'b0;
        br_target = 32'd0; id_allowin = 1'b0; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0; inst_rdata = 32'd0;
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);

        // Sequential fetch
        do_reset();
        run_log(3, 0);
        check("seq0", req_log[0], 32'hbfc0_0000);
        check("seq1", req_log[1], 32'hbfc0_0004);
        check("seq2", req_log[2], 32'hbfc0_0008);

        // Stall in HOLD, then resume at pc+4
        run_buf();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 0);
        run_log(4, 0);
        check("stall_resume", req_log[3], 32'hbfc0_000c);

        // Branch while 08 is outstanding: 0C skipped
        do_reset();
        run_log(3, 0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hbfc0_0100, 1'b1, 1'b1, 0);
        run_log(4, 0);
        check("br_wait", req_log[3], 32'hbfc0_0100);

        // Branch in HOLD of 08: 0C is the delay slot
        do_reset();
        run_log(3, 0);
        nominal(0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hbfc0_0100, 1'b1, 1'b1, 0);
        run_log(5, 0);
        check("br_hold_slot", req_log[3], 32'hbfc0_000c);
        check("br_hold_tgt", req_log[4], 32'hbfc0_0100);

        // Trap in WAIT with a slow return
        do_reset();
        run_log(2, 3);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 3);
        run_log(3, 0);
        check("trap_wait", req_log[2], EXC_A);

        // Trap and eret together: trap wins
        do_reset();
        run_log(1, 0);
        step(1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 32'd0, 1'b1, 1'b1, 0);
        run_log(2, 0);
        check("trap_eret", req_log[1], EXC_A);

        // Trap coinciding with addr_ok
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
        run_log(2, 0);
        check("trap_aok", req_log[1], EXC_A);

        // Eret in HOLD with id_allowin high
        do_reset();
        run_buf();
        step(1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 32'd0, 1'b1, 1'b1, 0);
        run_log(2, 0);
        check("eret_hold", req_log[1], 32'h8000_1000);

        // Reset mid-fetch
        do_reset();
        run_log(1, 2);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 0);
        check("rst_req", {31'd0, inst_req}, {31'd0, rst ? 1'b0 : 1'b1});
        req_log.delete();
        run_log(1, 0);
        check("rst_restart", req_log[0], RST_A);

        // fetch_pc+4 wraps
        do_reset();
        run_log(1, 0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hffff_fffc, 1'b1, 1'b1, 0);
        run_log(3, 0);
        check("wrap_tgt", req_log[1], 32'hffff_fffc);
        check("wrap_next", req_log[2], 32'd0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : ($urandom() & 32'hffff_fffc);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 39) == 0), ($urandom() & 32'hffff_fffc),
                 ($urandom_range(0, 7) == 0), bt, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)));
            if (req_log.size() > 16) req_log.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
